// File: rtl/ram_pkg.sv
`default_nettype none
//============================================================================
// Module   : ram_pkg
// Desc     : Shared types and default constants for the DRAM refresh scheduler.
// Revision : 1.0 - initial release
//============================================================================
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        GAP  = 2'd2
    } ref_state_t;

    localparam int REF_DEBT_W = 4;

    // Defaults: 15.6 us refresh interval at 25 MHz
    localparam int REF_PERIOD_DEF = 390;
    localparam int URG_DELAY_DEF  = 64;
    localparam int DEBT_URG_DEF   = 2;
    localparam int DEBT_MAX_DEF   = 7;

endpackage
`default_nettype wire

// File: rtl/ram_refresh_sched_if.sv
`default_nettype none
//============================================================================
// Module   : ram_refresh_sched_if
// Desc     : Refresh request/acknowledge bundle between scheduler and RAM
//            controller. RefOverrun exists only with REF_OVERRUN_FLAG_EN.
// Revision : 1.0 - initial release
//============================================================================
interface ram_refresh_sched_if;
    import ram_pkg::*;

    logic                  RefEN;
    logic                  RefAck;
    logic                  RefReq;
    logic                  RefUrg;
    logic [REF_DEBT_W-1:0] RefDebt;
`ifdef REF_OVERRUN_FLAG_EN
    logic                  RefOverrun;
`endif

`ifdef REF_OVERRUN_FLAG_EN
    modport master (
        output RefEN,
        output RefAck,
        input  RefReq,
        input  RefUrg,
        input  RefDebt,
        input  RefOverrun
    );

    modport slave (
        input  RefEN,
        input  RefAck,
        output RefReq,
        output RefUrg,
        output RefDebt,
        output RefOverrun
    );
`else
    modport master (
        output RefEN,
        output RefAck,
        input  RefReq,
        input  RefUrg,
        input  RefDebt
    );

    modport slave (
        input  RefEN,
        input  RefAck,
        output RefReq,
        output RefUrg,
        output RefDebt
    );
`endif

endinterface
`default_nettype wire

// File: rtl/ref_prescaler.sv
`default_nettype none
//============================================================================
// Module   : ref_prescaler
// Desc     : Free-running modulo-REF_PERIOD counter with synchronous clear;
//            Tick marks the last count of each period.
// Revision : 1.0 - initial release
//============================================================================
module ref_prescaler #(
    parameter int REF_PERIOD = 390
) (
    input  wire  CLK,
    input  wire  nRST,
    input  wire  Clr,
    output logic Tick
);

    localparam int              CNT_W  = $clog2(REF_PERIOD);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(REF_PERIOD - 1);

    logic [CNT_W-1:0] r_pcnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pcnt <= '0;
        end else if (Clr || (r_pcnt == C_LAST)) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + CNT_W'(1);
        end
    end

    assign Tick = (r_pcnt == C_LAST) && !Clr;

endmodule
`default_nettype wire

// File: rtl/ram_refresh_sched.sv
`default_nettype none
//============================================================================
// Module   : ram_refresh_sched
// Desc     : DRAM refresh scheduler: tracks owed refreshes (debt), drives
//            polite/urgent requests and a one-cycle gap after each ack.
//            Optional sticky overrun flag under REF_OVERRUN_FLAG_EN.
// Revision : 1.0 - initial release
//============================================================================
module ram_refresh_sched
    import ram_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int URG_DELAY  = URG_DELAY_DEF,
    parameter int DEBT_URG   = DEBT_URG_DEF,
    parameter int DEBT_MAX   = DEBT_MAX_DEF
) (
    input  wire                CLK,
    input  wire                nRST,
    ram_refresh_sched_if.slave bus
);

    localparam int AGE_W = $clog2(URG_DELAY + 1);

    localparam logic [AGE_W-1:0]      C_AGE_SAT  = AGE_W'(URG_DELAY);
    localparam logic [REF_DEBT_W-1:0] C_DEBT_MAX = REF_DEBT_W'(DEBT_MAX);
    localparam logic [REF_DEBT_W-1:0] C_DEBT_URG = REF_DEBT_W'(DEBT_URG);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_PEND = PEND;
    localparam logic [1:0] S_GAP  = GAP;

    if (REF_PERIOD < 4) begin : g_chk_period
        $error("REF_PERIOD must be at least 4");
    end
    if (URG_DELAY < 1) begin : g_chk_urg
        $error("URG_DELAY must be at least 1");
    end
    if ((DEBT_MAX < 1) || (DEBT_MAX > 15)) begin : g_chk_dmax
        $error("DEBT_MAX must be in 1..15");
    end
    if ((DEBT_URG < 1) || (DEBT_URG > DEBT_MAX)) begin : g_chk_durg
        $error("DEBT_URG must be in 1..DEBT_MAX");
    end

    logic                  w_clr;
    logic                  w_tick;
    logic                  w_ack;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [REF_DEBT_W-1:0] r_debt;
    logic [REF_DEBT_W-1:0] w_debt_nxt;
    logic [AGE_W-1:0]      r_age;
    logic [AGE_W-1:0]      w_age_nxt;
    logic                  r_req;
    logic                  r_urg;
    logic                  w_req_nxt;
    logic                  w_urg_nxt;

    assign w_clr = !bus.RefEN;

    ref_prescaler #(
        .REF_PERIOD (REF_PERIOD)
    ) u_prescaler (
        .CLK  (CLK),
        .nRST (nRST),
        .Clr  (w_clr),
        .Tick (w_tick)
    );

    // Acks are honoured only while a request is actually being driven
    assign w_ack = bus.RefAck && (r_state == S_PEND);

    always_comb begin
        w_debt_nxt = r_debt;
        if (w_tick && !w_ack) begin
            if (r_debt != C_DEBT_MAX) begin
                w_debt_nxt = r_debt + REF_DEBT_W'(1);
            end
        end else if (w_ack && !w_tick) begin
            w_debt_nxt = r_debt - REF_DEBT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_age_nxt   = r_age;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_PEND;
                    w_age_nxt   = '0;
                end
            end
            S_PEND: begin
                if (r_age != C_AGE_SAT) begin
                    w_age_nxt = r_age + AGE_W'(1);
                end
                if (w_ack) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                // Remaining debt resumes the request with its age intact
                if (w_debt_nxt != '0) begin
                    w_state_nxt = S_PEND;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_age_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_age_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_req_nxt = (w_state_nxt == S_PEND);
        w_urg_nxt = w_req_nxt &&
                    ((w_age_nxt >= C_AGE_SAT) || (w_debt_nxt >= C_DEBT_URG));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_debt  <= '0;
            r_age   <= '0;
            r_req   <= 1'b0;
            r_urg   <= 1'b0;
        end else if (w_clr) begin
            r_state <= S_IDLE;
            r_debt  <= '0;
            r_age   <= '0;
            r_req   <= 1'b0;
            r_urg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_debt  <= w_debt_nxt;
            r_age   <= w_age_nxt;
            r_req   <= w_req_nxt;
            r_urg   <= w_urg_nxt;
        end
    end

    assign bus.RefReq  = r_req;
    assign bus.RefUrg  = r_urg;
    assign bus.RefDebt = r_debt;

`ifdef REF_OVERRUN_FLAG_EN
    logic w_sat;
    logic r_ovr;

    // Saturating tick: a refresh period elapsed with no room left to record it
    assign w_sat = w_tick && !w_ack && (r_debt == C_DEBT_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ovr <= 1'b0;
        end else if (w_sat) begin
            r_ovr <= 1'b1;
        end
    end

    assign bus.RefOverrun = r_ovr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_refresh_sched.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_ram_refresh_sched
// Desc     : Self-checking bench for ram_refresh_sched (REF_OVERRUN_FLAG_EN
//            aware) with directed scenarios and randomized enable/ack.
// Revision : 1.0 - initial release
//============================================================================
module tb_ram_refresh_sched;

    localparam int P  = 10;
    localparam int U  = 4;
    localparam int DU = 2;
    localparam int DM = 3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

    ram_refresh_sched_if bus();

    ram_refresh_sched #(
        .REF_PERIOD (P),
        .URG_DELAY  (U),
        .DEBT_URG   (DU),
        .DEBT_MAX   (DM)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model: cycles into the current refresh period, owed refreshes,
    // whether a request is out / we are in the post-ack gap, and request age.
    int m_phase;
    int m_debt;
    int m_age;
    bit m_pend;
    bit m_gap;
    bit m_ovr;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_debt  = 0;
        m_age   = 0;
        m_pend  = 1'b0;
        m_gap   = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_edge(input bit en, input bit ack);
        bit tick;
        bit taken;
        if (!en) begin
            m_phase = 0;
            m_debt  = 0;
            m_age   = 0;
            m_pend  = 1'b0;
            m_gap   = 1'b0;
            return;
        end
        tick    = (m_phase == P - 1);
        m_phase = (m_phase + 1) % P;
        taken   = ack && m_pend;
        if (tick && !taken) begin
            if (m_debt == DM) m_ovr = 1'b1;
            else              m_debt = m_debt + 1;
        end else if (taken && !tick) begin
            m_debt = m_debt - 1;
        end
        if (m_pend) begin
            m_age = (m_age + 1 > U) ? U : m_age + 1;
            if (taken) begin
                m_pend = 1'b0;
                m_gap  = 1'b1;
            end
        end else if (m_gap) begin
            m_gap  = 1'b0;
            m_pend = (m_debt > 0);
            if (!m_pend) m_age = 0;
        end else if (tick) begin
            m_pend = 1'b1;
            m_age  = 0;
        end
    endfunction

    task automatic cmp_model();
        chk("req",  int'(bus.RefReq),  int'(m_pend));
        chk("urg",  int'(bus.RefUrg),  int'(m_pend && ((m_age >= U) || (m_debt >= DU))));
        chk("debt", int'(bus.RefDebt), m_debt);
`ifdef REF_OVERRUN_FLAG_EN
        chk("ovr",  int'(bus.RefOverrun), int'(m_ovr));
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge(bus.RefEN, bus.RefAck);
        @(negedge CLK);
        cmp_model();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        bus.RefEN  = 1'b1;
        bus.RefAck = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_req",  int'(bus.RefReq),  0);
        chk("rst_urg",  int'(bus.RefUrg),  0);
        chk("rst_debt", int'(bus.RefDebt), 0);
`ifdef REF_OVERRUN_FLAG_EN
        chk("rst_ovr",  int'(bus.RefOverrun), 0);
`endif
        nRST = 1'b1;

        // First tick, urgency by age, single ack with one-cycle gap
        run(9);
        chk("req_pre_tick", int'(bus.RefReq), 0);
        step();
        chk("req_at_10",  int'(bus.RefReq),  1);
        chk("debt_at_10", int'(bus.RefDebt), 1);
        chk("urg_at_10",  int'(bus.RefUrg),  0);
        run(3);
        chk("urg_at_13", int'(bus.RefUrg), 0);
        step();
        chk("urg_at_14", int'(bus.RefUrg), 1);
        bus.RefAck = 1'b1;
        step();
        bus.RefAck = 1'b0;
        chk("req_gap",  int'(bus.RefReq),  0);
        chk("debt_ack", int'(bus.RefDebt), 0);
        step();
        chk("req_idle", int'(bus.RefReq), 0);
        run(3);
        step();
        chk("req_at_20", int'(bus.RefReq), 1);

        // Unserviced: debt climbs to saturation and holds
        run(30);
        chk("debt_sat", int'(bus.RefDebt), DM);
        chk("urg_sat",  int'(bus.RefUrg),  1);
`ifdef REF_OVERRUN_FLAG_EN
        chk("ovr_set", int'(bus.RefOverrun), 1);
`endif

        // Disable clears everything but the overrun flag
        bus.RefEN = 1'b0;
        step();
        chk("en_off_req",  int'(bus.RefReq),  0);
        chk("en_off_debt", int'(bus.RefDebt), 0);
`ifdef REF_OVERRUN_FLAG_EN
        chk("ovr_kept", int'(bus.RefOverrun), 1);
`endif
        bus.RefEN = 1'b1;
        run(20);
        chk("debt_two", int'(bus.RefDebt), 2);

        // Tick and ack coincide, then a spurious ack during the gap
        run(9);
        bus.RefAck = 1'b1;
        step();
        chk("coinc_debt", int'(bus.RefDebt), 2);
        chk("coinc_req",  int'(bus.RefReq),  0);
        step();
        bus.RefAck = 1'b0;
        chk("gapack_debt", int'(bus.RefDebt), 2);
        chk("gapack_req",  int'(bus.RefReq),  1);

        // Spurious ack while idle
        bus.RefEN = 1'b0;
        step();
        bus.RefEN  = 1'b1;
        bus.RefAck = 1'b1;
        run(5);
        bus.RefAck = 1'b0;
        chk("idleack_debt", int'(bus.RefDebt), 0);
        chk("idleack_req",  int'(bus.RefReq),  0);

        // Randomized enable and acknowledge traffic
        for (int i = 0; i < 600; i++) begin
            bus.RefEN  = ($urandom_range(0, 99) >= 3);
            bus.RefAck = ($urandom_range(0, 99) < 15);
            step();
        end
        bus.RefEN  = 1'b1;
        bus.RefAck = 1'b0;

        // Disable with debt pending, then asynchronous reset mid-request
        bus.RefEN = 1'b0;
        step();
        bus.RefEN = 1'b1;
        run(20);
        chk("pre_off_debt", int'(bus.RefDebt), 2);
        bus.RefEN = 1'b0;
        step();
        chk("off2_req",  int'(bus.RefReq),  0);
        chk("off2_urg",  int'(bus.RefUrg),  0);
        chk("off2_debt", int'(bus.RefDebt), 0);
        bus.RefEN = 1'b1;
        run(12);
        chk("pend_before_rst", int'(bus.RefReq), 1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_req",  int'(bus.RefReq),  0);
        chk("arst_urg",  int'(bus.RefUrg),  0);
        chk("arst_debt", int'(bus.RefDebt), 0);
`ifdef REF_OVERRUN_FLAG_EN
        chk("arst_ovr",  int'(bus.RefOverrun), 0);
`endif
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        run(9);
        chk("rst2_pre_tick", int'(bus.RefReq), 0);
        step();
        chk("rst2_req", int'(bus.RefReq), 1);
        run(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
